// File: rtl/input_debounce.sv
// Pad input conditioner: synchroniser, stability-counter debouncer, edge pulses
// and a wrapping count of accepted rising transitions.
module input_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             din,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_count
);

  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit          ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    LO      = 2'd0,
    PEND_HI = 2'd1,
    HI      = 2'd2,
    PEND_LO = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   at_target;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       edge_count_q, edge_count_d;

  assign s         = sync_q[SYNC_STAGES-1];
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], din};
  assign cnt_inc   = cnt_q + CW'(1);
  assign at_target = (cnt_inc == CW'(DEBOUNCE_CYCLES));

  // Next-state and registered-output logic; everything holds while ena is low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    edge_count_d = edge_count_q;

    if (ena) begin
      case (state_q)
        LO: begin
          if (s) begin
            if (ONE_SHOT) begin
              state_d      = HI;
              dout_d       = 1'b1;
              rise_d       = 1'b1;
              edge_count_d = edge_count_q + CNT_W'(1);
            end else begin
              state_d = PEND_HI;
              cnt_d   = CW'(1);
            end
          end
        end
        PEND_HI: begin
          if (s) begin
            if (at_target) begin
              state_d      = HI;
              cnt_d        = '0;
              dout_d       = 1'b1;
              rise_d       = 1'b1;
              edge_count_d = edge_count_q + CNT_W'(1);
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = LO;
            cnt_d   = '0;
          end
        end
        HI: begin
          if (!s) begin
            if (ONE_SHOT) begin
              state_d = LO;
              dout_d  = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d = PEND_LO;
              cnt_d   = CW'(1);
            end
          end
        end
        PEND_LO: begin
          if (!s) begin
            if (at_target) begin
              state_d = LO;
              cnt_d   = '0;
              dout_d  = 1'b0;
              fall_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = HI;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = LO;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= LO;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      busy_q       <= 1'b0;
      edge_count_q <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      busy_q       <= busy_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign busy       = busy_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce: a run-length reference model predicts
// each cycle's outputs, a monitor pops and compares after every clock edge.
module tb_input_debounce;

  localparam int unsigned S_ST  = 2;
  localparam int unsigned DEB   = 16;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic             dout;
    logic             rise;
    logic             fall;
    logic             busy;
    logic [CNT_W-1:0] ec;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ena = 1'b1;
  logic             din = 1'b0;
  logic             dout, rise, fall, busy;
  logic [CNT_W-1:0] edge_count;

  int total = 0;
  int bad   = 0;

  obs_t exp_q[$];

  // Reference model: delay line for the synchroniser, then a level and the
  // length of the current run of samples disagreeing with it.
  logic m_sync[S_ST];
  logic m_level;
  int   m_run;
  int   m_ec;
  logic m_rise, m_fall;

  input_debounce #(
    .SYNC_STAGES    (S_ST),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .din       (din),
    .dout      (dout),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_obs();
    obs_t o;
    o.dout = m_level;
    o.rise = m_rise;
    o.fall = m_fall;
    o.busy = (m_run != 0);
    o.ec   = CNT_W'(m_ec);
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(S_ST); i++) m_sync[i] = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
    m_ec    = 0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
  endtask

  task automatic model_edge(input logic d, input logic e, input logic r);
    logic smp;
    if (r) begin
      model_reset();
    end else begin
      smp    = m_sync[S_ST-1];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (e) begin
        if (smp != m_level) begin
          m_run++;
          if (m_run >= int'(DEB)) begin
            m_level = smp;
            m_run   = 0;
            if (smp) begin
              m_rise = 1'b1;
              m_ec   = (m_ec + 1) % (1 << CNT_W);
            end else begin
              m_fall = 1'b1;
            end
          end
        end else begin
          m_run = 0;
        end
      end
      for (int i = int'(S_ST) - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = d;
    end
  endtask

  // Drive one cycle's inputs on the falling edge and queue the prediction.
  task automatic step(input logic d, input logic e, input logic r);
    @(negedge clk);
    din = d;
    ena = e;
    rst = r;
    model_edge(d, e, r);
    exp_q.push_back(model_obs());
  endtask

  task automatic run(input logic d, input logic e, input int n);
    for (int i = 0; i < n; i++) step(d, e, 1'b0);
  endtask

  task automatic check_zero(input string name);
    obs_t got;
    got = {dout, rise, fall, busy, edge_count};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL %s: got dout=%0b rise=%0b fall=%0b busy=%0b ec=%0d, required all zero",
               name, dout, rise, fall, busy, edge_count);
    end
  endtask

  // Monitor: every edge presents a fresh set of registered outputs.
  always @(posedge clk) begin
    obs_t got, e;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {dout, rise, fall, busy, edge_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL cycle t=%0t: got dout=%0b rise=%0b fall=%0b busy=%0b ec=%0d, required dout=%0b rise=%0b fall=%0b busy=%0b ec=%0d",
                 $time, got.dout, got.rise, got.fall, got.busy, got.ec,
                 e.dout, e.rise, e.fall, e.busy, e.ec);
      end
    end
  end

  initial begin
    int len;
    logic lvl;
    model_reset();

    // Reset asserted asynchronously with din high.
    din = 1'b1;
    #2 rst = 1'b1;
    #1 check_zero("reset_async");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    run(1'b1, 1'b1, 25);

    // Glitch rejection from HI, then from LO at 15 and 16 cycles.
    run(1'b0, 1'b1, 15);
    run(1'b1, 1'b1, 25);
    run(1'b0, 1'b1, 25);
    run(1'b1, 1'b1, 15);
    run(1'b0, 1'b1, 25);
    run(1'b1, 1'b1, 16);
    run(1'b0, 1'b1, 25);

    // Enable hold mid-pending.
    run(1'b1, 1'b1, 7);
    run(1'b1, 1'b0, 10);
    run(1'b1, 1'b1, 20);
    run(1'b0, 1'b1, 25);

    // Toggling every cycle never settles.
    for (int i = 0; i < 40; i++) step(1'(i % 2), 1'b1, 1'b0);
    run(1'b0, 1'b1, 5);

    // 256 clean rising transitions wrap edge_count.
    for (int i = 0; i < 256; i++) begin
      run(1'b1, 1'b1, 20);
      run(1'b0, 1'b1, 20);
    end

    // Async reset at cnt=10 in PEND_HI, between clock edges.
    run(1'b1, 1'b1, 12);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1 check_zero("reset_mid_pending");
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run(1'b1, 1'b1, 17);
    run(1'b1, 1'b1, 10);
    run(1'b0, 1'b1, 25);

    // Randomised runs with occasional enable drops and resets.
    lvl = 1'b0;
    for (int k = 0; k < 300; k++) begin
      lvl = ~lvl;
      len = int'($urandom_range(1, 24));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 299) == 0) step(lvl, 1'b1, 1'b1);
        else step(lvl, ($urandom_range(0, 7) != 0), 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
# input_debounce

Input conditioning stage that sits directly upstream of the inverter-chain logic and drives its single data input. It synchronises a raw, possibly bouncing pad signal into the `clk` domain, debounces it with a stability counter, and presents a clean level plus one-cycle rise/fall pulses and a wrapping rising-edge count. The inverter chain then consumes `dout`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flop depth. Legal values are 2 or more.
- `DEBOUNCE_CYCLES`, 16: consecutive mismatching synchronised samples required to accept a new level. Legal values are 1 or more.
- `CNT_W`, 8: width of `edge_count`.

Ports:
- `clk`  in  1  sole clock. All logic is rising-edge.
- `rst`  in  1  reset. Asynchronous, active-high, one clock domain.
- `ena`  in  1  debounce enable. While low, the stability counter holds and no transitions occur.
- `din`  in  1  raw asynchronous input (pad `ui_in[0]`).
- `dout`  out  1  debounced level. Feeds the inverter chain.
- `rise`  out  1  one-cycle pulse, high in the cycle `dout` becomes 1.
- `fall`  out  1  one-cycle pulse, high in the cycle `dout` becomes 0.
- `busy`  out  1  high while a candidate transition is pending.
- `edge_count`  out  `CNT_W`  number of accepted rising transitions, modulo 2^`CNT_W`.

## Operation
- Synchroniser:
  - `SYNC_STAGES` flops in series, reset to 0. The last stage is `s`.
  - The synchroniser runs regardless of `ena`.
- Stability counter `cnt`:
  - Width is clog2(`DEBOUNCE_CYCLES`+1). Reset value is 0.
- FSM states and transitions, evaluated when `ena`=1 (reset state is `LO`):
  - `LO`: `dout`=0. On s=1, go to `PEND_HI` with `cnt`=1. If `DEBOUNCE_CYCLES`=1, go straight to `HI` instead.
  - `PEND_HI`: on s=1, increment `cnt`. When the incremented value equals `DEBOUNCE_CYCLES`, go to `HI` and clear `cnt`. On s=0, return to `LO` and clear `cnt` (glitch rejected).
  - `HI`: `dout`=1. Symmetric to `LO`, using s=0 and `PEND_LO`.
  - `PEND_LO`: symmetric to `PEND_HI`.
- Transition outputs:
  - Entering `HI` sets `dout`=1 and `rise`=1 for one cycle, and increments `edge_count`.
  - Entering `LO` from `PEND_LO` sets `dout`=0 and `fall`=1 for one cycle.
- `edge_count` wraps from 2^`CNT_W`−1 to 0 with no flag.
- `busy` = state is `PEND_HI` or `PEND_LO`.
- With `ena`=0:
  - State, `cnt`, `dout` and `edge_count` hold.
  - `rise` and `fall` are 0.
  - `busy` reflects the held state.
- When `ena` rises again, evaluation resumes from the held `cnt`. There is no implicit clear.
- All outputs are registered. There is no combinational path from `din` to any output.

## Timing
Reset values, applied asynchronously on `rst`=1 and held until the first edge after release:
- `dout`=0, `rise`=0, `fall`=0, `busy`=0, `edge_count`=0.
- Sync flops 0, `cnt`=0, state `LO`.

Latency:
- Let `din` change and stay stable before edge 1, with `ena`=1.
- `s` reflects the new value after edge `SYNC_STAGES`.
- The first mismatch is counted at edge `SYNC_STAGES`+1.
- `dout` and the pulse update at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With default parameters this is edge 18.

Glitch rejection:
- A synchronised excursion lasting `DEBOUNCE_CYCLES`−1 cycles or fewer produces no output change.
- When the excursion ends, `busy` drops at the edge where `s` returns.

`rise` and `fall`:
- Each is high for exactly one cycle.
- They are never high simultaneously.
- The minimum spacing between them is `DEBOUNCE_CYCLES` cycles.

Reset mid-operation:
- `rst` asserted during a `PEND_*` state aborts the transition with no pulse.
- All outputs drop to reset values immediately, without waiting for a clock edge.

`din` toggling every cycle: `dout` never changes, since `cnt` is cleared on each return.

## Test plan
- Reset check:
  - Assert `rst` with `din`=1 held.
  - Required: all outputs 0. After release, `dout`=1 at edge 18, `rise` high for that single cycle, `edge_count`=1.
- Glitch rejection:
  - From `LO`, drive `din` high for 15 cycles, then low.
  - Required: `dout` stays 0, `busy` high for 15 cycles then low, no pulse.
  - Repeat with 16 cycles. Required: `dout`=1 at edge 18.
- Fall path:
  - From `HI`, drive `din` low.
  - Required: `fall` for one cycle at edge 18, `dout`=0, `edge_count` unchanged.
- Enable hold:
  - Raise `din`, drop `ena` after 5 counted cycles for 10 cycles, then restore `ena`.
  - Required: `busy` stays 1, `dout` stays 0 during the hold. `dout` rises 11 counted cycles after `ena` returns.
- Counter wrap:
  - Perform 256 clean rising transitions.
  - Required: `edge_count` reads 255 after the 255th and 0 after the 256th.
- Async reset mid-pending:
  - Assert `rst` between clock edges at `cnt`=10 in `PEND_HI`.
  - Required: `busy`, `dout` and `edge_count` are 0 before the next edge. No `rise` is emitted afterwards unless `din` is held for a full 18 edges from release.
